fu_writeback_stage: RTL and testbench
=====================================

// Module: fu_writeback_stage
// PURPOSE
//  Stage directly downstream of Mod_Function_unit: captures F plus Z/C/N/V each issue, buffers them
//  in a 2-entry skid queue, retires them to the register-file write port in order and maintains the
//  architectural status register (SR). Exposes the youngest pending write for operand forwarding.
// PARAMETERS
//  DATA_W      10  width of F / register data
//  REG_ADDR_W  3   destination register address width (8 registers)
// PORTS
//  CLK        in   1           single clock, all state on rising edge
//  RESET_N    in   1           synchronous, active-low reset
//  in_valid   in   1           function-unit result valid this cycle
//  in_ready   out  1           stage can accept (registered; low when queue full)
//  F          in   DATA_W      function-unit result
//  Z_in,C_in,N_in,V_in in 1 ea  function-unit flags for F
//  DA         in   REG_ADDR_W  destination register
//  RW         in   1           write F to DA on retire
//  FL         in   1           update SR from flags on retire
//  out_ready  in   1           register file / writeback port accepts this cycle
//  rf_we      out  1           retire strobe with write (= out_valid & RW of head)
//  out_valid  out  1           head entry present
//  rf_addr    out  REG_ADDR_W  head DA
//  rf_data    out  DATA_W      head F
//  SR         out  4           status register {V,N,C,Z}
//  fwd_valid  out  1           some queued entry has RW=1
//  fwd_addr   out  REG_ADDR_W  DA of youngest queued RW=1 entry
//  fwd_data   out  DATA_W      F of that entry
// BEHAVIOUR
//  - Reset (RESET_N=0 at edge): queue emptied, SR=4'b0000, out_valid=0, rf_we=0, in_ready=1,
//    fwd_valid=0, rf_addr/rf_data/fwd_addr/fwd_data=0. Reset mid-operation discards queued entries;
//    no retire strobe occurs in the reset cycle.
//  - Push: in_valid & in_ready at edge stores {F,flags,DA,RW,FL} at tail. in_valid while
//    in_ready=0 is ignored (upstream must hold).
//  - Pop: out_valid & out_ready at edge removes head. On that edge, if head FL=1, SR <= head flags;
//    if FL=0, SR holds. RW=0/FL=0 entries still occupy a slot and retire in order.
//  - Latency: result pushed at edge n is at head with out_valid=1 from edge n (after n) if queue was
//    empty, i.e. visible the next cycle; no combinational path in->out.
//  - Occupancy FSM: EMPTY -> ONE (push only), ONE -> TWO (push, no pop), ONE -> EMPTY (pop, no push),
//    ONE -> ONE (push+pop), TWO -> ONE (pop). In TWO, in_ready=0 so no push; pop+push same edge not
//    allowed in TWO. in_ready = (next state != TWO), registered.
//  - Order: strict FIFO; 2 slots as head/tail registers or 1-bit ring pointers (wrap at 2).
//  - rf_we, rf_addr, rf_data are combinational from head registers; rf_we=out_valid & head.RW.
//  - Forwarding: if tail entry RW=1 it wins, else head if RW=1; fwd_valid=0 when none or EMPTY.
//    Two entries with the same DA: youngest (tail) is reported.
//  - Flag widths unchanged: flags stored as received, no recomputation from F.
// STRUCTURE
//  - Shared package fu_pkg: DATA_W, REG_ADDR_W, typedef wb_entry_t {data,z,c,n,v,da,rw,fl},
//    occupancy enum {EMPTY,ONE,TWO}, SR bit indices (SR_Z=0,SR_C=1,SR_N=2,SR_V=3).
//  - One sub-module: fu_skid_queue2 (2-entry FIFO of wb_entry_t with valid/ready both sides);
//    SR update and forwarding mux live in fu_writeback_stage.
// TESTING
//  - Reset: drive RESET_N=0 with queue TWO full, SR=4'hF -> next cycle out_valid=0, SR=0, in_ready=1.
//  - Single pass: push F=10'h155, DA=3, RW=1, FL=1, flags Z0 C1 N0 V0, out_ready=1 -> next cycle
//    rf_we=1 rf_addr=3 rf_data=10'h155; edge after -> SR=4'b0010, out_valid=0.
//  - Backpressure: out_ready=0, push 3 results back-to-back -> in_ready=0 after 2nd; 3rd held;
//    release out_ready -> retires 1st,2nd,3rd in order, no loss/dup.
//  - FL=0 retire: SR=4'b0001 then retire entry with FL=1 flags and FL=0 -> SR unchanged 4'b0001.
//  - Forwarding: queue head DA=2 F=10'h00A RW=1, tail DA=2 F=10'h3FF RW=1 -> fwd_addr=2
//    fwd_data=10'h3FF; tail RW=0 -> fwd_data=10'h00A.
//  - Push+pop same cycle in ONE: occupancy stays ONE, head replaced by new entry, rf_we pulses once.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared types and constants for the function-unit writeback stage: entry layout,
// occupancy encoding and status-register bit positions.
package fu_pkg;

  localparam int DATA_W     = 10;
  localparam int REG_ADDR_W = 3;

  localparam int SR_Z = 0;
  localparam int SR_C = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 3;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic                  z;
    logic                  c;
    logic                  n;
    logic                  v;
    logic [REG_ADDR_W-1:0] da;
    logic                  rw;
    logic                  fl;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fu_skid_queue2.sv
// Two-entry in-order FIFO of writeback entries held in head/tail registers.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// ready is registered, and the entry at the head stays stable until it is popped.
module fu_skid_queue2
  import fu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_valid_i,
  output logic      push_ready_o,
  input  wb_entry_t push_entry_i,
  output logic      pop_valid_o,
  input  logic      pop_ready_i,
  output wb_entry_t head_o,
  output wb_entry_t tail_o,
  output occ_e      occ_o
);

  occ_e      state_q;
  wb_entry_t head_q;
  wb_entry_t tail_q;
  logic      ready_q;
  logic      push;
  logic      pop;

  assign push = push_valid_i & ready_q;
  assign pop  = (state_q != EMPTY) & pop_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= push_entry_i;
            state_q <= ONE;
          end
          ready_q <= 1'b1;
        end
        ONE: begin
          // Simultaneous push and pop replaces the single entry in place.
          if (push && pop) begin
            head_q  <= push_entry_i;
            ready_q <= 1'b1;
          end else if (push) begin
            tail_q  <= push_entry_i;
            state_q <= TWO;
            ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign push_ready_o = ready_q;
  assign pop_valid_o  = (state_q != EMPTY);
  assign head_o       = head_q;
  assign tail_o       = tail_q;
  assign occ_o        = state_q;

endmodule

// File: rtl/fu_writeback_stage.sv
// Writeback stage: queues function-unit results, retires them in order to the register
// file, maintains the status register and forwards the youngest pending register write.
module fu_writeback_stage
  import fu_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     F,
  input  logic                  Z_in,
  input  logic                  C_in,
  input  logic                  N_in,
  input  logic                  V_in,
  input  logic [REG_ADDR_W-1:0] DA,
  input  logic                  RW,
  input  logic                  FL,
  input  logic                  out_ready,
  output logic                  rf_we,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [3:0]            SR,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
);

  wb_entry_t in_entry;
  wb_entry_t head;
  wb_entry_t tail;
  occ_e      occ;
  logic      pop;
  logic [3:0] sr_q;
  logic [3:0] sr_d;

  assign in_entry = '{data: F, z: Z_in, c: C_in, n: N_in, v: V_in, da: DA, rw: RW, fl: FL};

  fu_skid_queue2 u_queue (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_entry_i (in_entry),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .head_o       (head),
    .tail_o       (tail),
    .occ_o        (occ)
  );

  assign pop     = out_valid & out_ready;
  assign rf_we   = out_valid & head.rw;
  assign rf_addr = head.da;
  assign rf_data = head.data;

  always_comb begin
    sr_d = sr_q;
    if (pop && head.fl) begin
      sr_d[SR_Z] = head.z;
      sr_d[SR_C] = head.c;
      sr_d[SR_N] = head.n;
      sr_d[SR_V] = head.v;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) sr_q <= 4'b0000;
    else          sr_q <= sr_d;
  end

  assign SR = sr_q;

  // The tail is younger than the head, so a writing tail shadows the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (occ == TWO && tail.rw) begin
      fwd_valid = 1'b1;
      fwd_addr  = tail.da;
      fwd_data  = tail.data;
    end else if (occ != EMPTY && head.rw) begin
      fwd_valid = 1'b1;
      fwd_addr  = head.da;
      fwd_data  = head.data;
    end
  end

endmodule

// File: tb/tb_fu_writeback_stage.sv
// Randomized and directed bench for fu_writeback_stage against a queue-based reference model.
module tb_fu_writeback_stage;
  import fu_pkg::*;

  logic                  CLK;
  logic                  RESET_N;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     F;
  logic                  Z_in, C_in, N_in, V_in;
  logic [REG_ADDR_W-1:0] DA;
  logic                  RW;
  logic                  FL;
  logic                  out_ready;
  logic                  rf_we;
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic [3:0]            SR;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;

  fu_writeback_stage dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (F),
    .Z_in      (Z_in),
    .C_in      (C_in),
    .N_in      (N_in),
    .V_in      (V_in),
    .DA        (DA),
    .RW        (RW),
    .FL        (FL),
    .out_ready (out_ready),
    .rf_we     (rf_we),
    .out_valid (out_valid),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .SR        (SR),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  wb_entry_t  exp_q[$];
  logic [3:0] sr_m;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wb_entry_t mk(input logic [9:0] d, input logic [3:0] vncz,
                                   input logic [2:0] da, input logic rw, input logic fl);
    wb_entry_t e;
    e.data = d;
    e.v = vncz[3]; e.n = vncz[2]; e.c = vncz[1]; e.z = vncz[0];
    e.da = da; e.rw = rw; e.fl = fl;
    return e;
  endfunction

  task automatic compare_model();
    int        n;
    logic      fv;
    wb_entry_t fe;
    n  = exp_q.size();
    fv = 1'b0;
    fe = '0;
    for (int k = n - 1; k >= 0; k--)
      if (!fv && exp_q[k].rw) begin
        fv = 1'b1;
        fe = exp_q[k];
      end
    check("out_valid", 32'(out_valid), 32'(n > 0));
    check("in_ready",  32'(in_ready),  32'(n < 2));
    check("sr",        32'(SR),        32'(sr_m));
    check("fwd_valid", 32'(fwd_valid), 32'(fv));
    if (n > 0) begin
      check("rf_we",   32'(rf_we),   32'(exp_q[0].rw));
      check("rf_addr", 32'(rf_addr), 32'(exp_q[0].da));
      check("rf_data", 32'(rf_data), 32'(exp_q[0].data));
    end else begin
      check("rf_we_idle", 32'(rf_we), 32'(0));
    end
    if (fv) begin
      check("fwd_addr", 32'(fwd_addr), 32'(fe.da));
      check("fwd_data", 32'(fwd_data), 32'(fe.data));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle of inputs, advances the model across the
  // rising edge, then checks the DUT at the next falling edge.
  task automatic step(input logic iv, input wb_entry_t e, input logic ordy, input logic rstn);
    logic push, pop;
    in_valid  = iv;
    F = e.data; Z_in = e.z; C_in = e.c; N_in = e.n; V_in = e.v;
    DA = e.da; RW = e.rw; FL = e.fl;
    out_ready = ordy;
    RESET_N   = rstn;
    if (!rstn) begin
      exp_q.delete();
      sr_m = 4'b0000;
    end else begin
      push = iv && (exp_q.size() < 2);
      pop  = ordy && (exp_q.size() > 0);
      if (pop) begin
        if (exp_q[0].fl) sr_m = {exp_q[0].v, exp_q[0].n, exp_q[0].c, exp_q[0].z};
        void'(exp_q.pop_front());
      end
      if (push) exp_q.push_back(e);
    end
    @(posedge CLK);
    @(negedge CLK);
    compare_model();
  endtask

  wb_entry_t idle, a, b, c, x, y;

  initial begin
    idle = mk(10'h000, 4'h0, 3'd0, 1'b0, 1'b0);
    sr_m = 4'b0000;
    RESET_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    F = '0; Z_in = 0; C_in = 0; N_in = 0; V_in = 0; DA = '0; RW = 0; FL = 0;
    @(negedge CLK);
    step(1'b0, idle, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    check("rst_rf_addr",  32'(rf_addr),  32'(0));
    check("rst_rf_data",  32'(rf_data),  32'(0));
    check("rst_fwd_addr", 32'(fwd_addr), 32'(0));
    check("rst_fwd_data", 32'(fwd_data), 32'(0));

    // single pass
    step(1'b1, mk(10'h155, 4'b0010, 3'd3, 1'b1, 1'b1), 1'b1, 1'b1);
    check("sp_rf_we",   32'(rf_we),   32'(1));
    check("sp_rf_addr", 32'(rf_addr), 32'(3));
    check("sp_rf_data", 32'(rf_data), 32'(10'h155));
    step(1'b0, idle, 1'b1, 1'b1);
    check("sp_sr",        32'(SR),        32'(4'b0010));
    check("sp_out_valid", 32'(out_valid), 32'(0));

    // backpressure: third result is held upstream until a slot frees
    a = mk(10'h101, 4'h0, 3'd1, 1'b1, 1'b0);
    b = mk(10'h102, 4'h0, 3'd2, 1'b1, 1'b0);
    c = mk(10'h103, 4'h0, 3'd3, 1'b1, 1'b0);
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    check("bp_full_ready", 32'(in_ready), 32'(0));
    step(1'b1, c, 1'b0, 1'b1);
    check("bp_head_a", 32'(rf_data), 32'(10'h101));
    step(1'b1, c, 1'b1, 1'b1);
    check("bp_head_b", 32'(rf_data), 32'(10'h102));
    step(1'b1, c, 1'b1, 1'b1);
    check("bp_head_c", 32'(rf_data), 32'(10'h103));
    step(1'b0, idle, 1'b1, 1'b1);
    check("bp_drained", 32'(out_valid), 32'(0));

    // FL=0 retire leaves SR untouched
    step(1'b1, mk(10'h000, 4'b0001, 3'd0, 1'b0, 1'b1), 1'b1, 1'b1);
    step(1'b0, idle, 1'b1, 1'b1);
    check("fl1_sr", 32'(SR), 32'(4'b0001));
    step(1'b1, mk(10'h000, 4'b1111, 3'd0, 1'b0, 1'b0), 1'b1, 1'b1);
    step(1'b0, idle, 1'b1, 1'b1);
    check("fl0_sr", 32'(SR), 32'(4'b0001));

    // forwarding: same destination twice, youngest wins
    step(1'b1, mk(10'h00A, 4'h0, 3'd2, 1'b1, 1'b0), 1'b0, 1'b1);
    step(1'b1, mk(10'h3FF, 4'h0, 3'd2, 1'b1, 1'b0), 1'b0, 1'b1);
    check("fwd_tail_addr", 32'(fwd_addr), 32'(2));
    check("fwd_tail_data", 32'(fwd_data), 32'(10'h3FF));
    step(1'b0, idle, 1'b1, 1'b1);
    step(1'b0, idle, 1'b1, 1'b1);
    step(1'b1, mk(10'h00A, 4'h0, 3'd2, 1'b1, 1'b0), 1'b0, 1'b1);
    step(1'b1, mk(10'h3FF, 4'h0, 3'd2, 1'b0, 1'b0), 1'b0, 1'b1);
    check("fwd_head_valid", 32'(fwd_valid), 32'(1));
    check("fwd_head_data",  32'(fwd_data),  32'(10'h00A));
    step(1'b0, idle, 1'b1, 1'b1);
    step(1'b0, idle, 1'b1, 1'b1);

    // push+pop while holding one entry
    x = mk(10'h2AA, 4'h0, 3'd5, 1'b1, 1'b0);
    y = mk(10'h0F0, 4'h0, 3'd6, 1'b1, 1'b0);
    step(1'b1, x, 1'b0, 1'b1);
    step(1'b1, y, 1'b1, 1'b1);
    check("pp_out_valid", 32'(out_valid), 32'(1));
    check("pp_in_ready",  32'(in_ready),  32'(1));
    check("pp_rf_addr",   32'(rf_addr),   32'(6));
    check("pp_rf_data",   32'(rf_data),   32'(10'h0F0));
    step(1'b0, idle, 1'b1, 1'b1);

    // reset with the queue full and SR all ones
    step(1'b1, mk(10'h000, 4'hF, 3'd0, 1'b0, 1'b1), 1'b1, 1'b1);
    step(1'b0, idle, 1'b1, 1'b1);
    check("rs_sr_set", 32'(SR), 32'(4'hF));
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    check("rs_full", 32'(in_ready), 32'(0));
    step(1'b0, idle, 1'b1, 1'b0);
    check("rs_out_valid", 32'(out_valid), 32'(0));
    check("rs_sr",        32'(SR),        32'(0));
    check("rs_in_ready",  32'(in_ready),  32'(1));
    check("rs_rf_we",     32'(rf_we),     32'(0));
    check("rs_fwd_valid", 32'(fwd_valid), 32'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           mk(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
